// File: rtl/level_pkg.sv
// Shared definitions for the typing-level game controller: FSM states,
// per-level word lengths, ASCII codes and the word text behind the ROM.
package level_pkg;

    localparam int NUM_WORDS  = 3;
    localparam int WORD_SLOTS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PLAY  = 3'd2,
        CHECK = 3'd3,
        WON   = 3'd4,
        LOST  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [3:0] LVL_LEN [NUM_WORDS] = '{4'd5, 4'd6, 4'd7};

    localparam logic [7:0] ASCII_BS      = 8'h08;
    localparam logic [7:0] ASCII_SPACE   = 8'h20;
    localparam logic [7:0] ASCII_DEL_MAX = 8'h7E;
    localparam logic [7:0] LOWER_A       = 8'h61;
    localparam logic [7:0] LOWER_Z       = 8'h7A;
    localparam logic [7:0] CASE_OFFSET   = 8'h20;

    // Full source text per level, first character in the top byte; each
    // level only exposes its first LVL_LEN characters.
    localparam logic [8*WORD_SLOTS-1:0] WORD_TEXT [NUM_WORDS] = '{
        "LOGIC   ",
        "FPGAVGA ",
        "FPGAVGA "
    };

    function automatic logic [3:0] lvl_len(input int unsigned lvl);
        case (lvl)
            0:       return LVL_LEN[0];
            1:       return LVL_LEN[1];
            2:       return LVL_LEN[2];
            default: return 4'd0;
        endcase
    endfunction

    // Target character at (lvl, idx); anything outside a word reads as space.
    function automatic logic [7:0] word_char(input int unsigned lvl, input int unsigned idx);
        logic [8*WORD_SLOTS-1:0] text;
        logic [8*WORD_SLOTS-1:0] shifted;
        case (lvl)
            0:       text = WORD_TEXT[0];
            1:       text = WORD_TEXT[1];
            2:       text = WORD_TEXT[2];
            default: text = {WORD_SLOTS{ASCII_SPACE}};
        endcase
        if (idx >= 32'(lvl_len(lvl))) return ASCII_SPACE;
        shifted = text << (8 * idx);
        return shifted[8*WORD_SLOTS-1 -: 8];
    endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// Control/status bundle between the keyboard/video side and the sequencer.
interface level_sequencer_if #(
    parameter int NUM_LEVELS = 3,
    parameter int MAX_LEN    = 8
) ();
    localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

    logic                start;
    logic                key_valid;
    logic [7:0]          key_char;
    logic                frame_tick;

    logic [2:0]          state;
    logic [LW-1:0]       level;
    logic [7:0]          counter;
    logic [3:0]          word_len;
    logic [MAX_LEN-1:0]  hit;
    logic [MAX_LEN-1:0]  miss;
    logic                lvl_won;
    logic                game_won;

    modport master (
        output start, key_valid, key_char, frame_tick,
        input  state, level, counter, word_len, hit, miss, lvl_won, game_won
    );

    modport slave (
        input  start, key_valid, key_char, frame_tick,
        output state, level, counter, word_len, hit, miss, lvl_won, game_won
    );
endinterface

// File: rtl/word_rom.sv
// Synchronous word ROM: one-cycle read of the target character at {level, index}.
module word_rom #(
    parameter int LW = 2,
    parameter int IW = 3
) (
    input  logic              clk,
    input  logic [LW+IW-1:0]  addr,
    output logic [7:0]        data
);
    import level_pkg::*;

    // Registered read of the constant table.
    // NOTE: ROM output register carries no reset; like a block-RAM read port it is
    // simply overwritten each cycle and nothing consumes it before the first read.
    always_ff @(posedge clk) begin
        data <= word_char(32'(addr[LW+IW-1:IW]), 32'(addr[IW-1:0]));
    end
endmodule

// File: rtl/level_sequencer.sv
// Typing-game controller: level/attempt FSM, per-position hit/miss record,
// keystroke judging against the word ROM, hold timing on WON/LOST.
module level_sequencer #(
    parameter int NUM_LEVELS  = 3,
    parameter int MAX_LEN     = 8,
    parameter int HOLD_FRAMES = 120
) (
    input  logic               clk,
    input  logic               reset,
    level_sequencer_if.slave   bus
);
    import level_pkg::*;

    localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int HW = $clog2(HOLD_FRAMES + 1);

    state_t              state;
    logic [LW-1:0]       level;
    logic [7:0]          counter;
    logic [3:0]          word_len;
    logic [MAX_LEN-1:0]  hit;
    logic [MAX_LEN-1:0]  miss;
    logic [HW-1:0]       hold_cnt;
    logic [7:0]          key_q;

    logic [7:0]          rom_data;
    logic [7:0]          key_up;
    logic                key_print;
    logic                key_bs;
    logic [IW-1:0]       cur_idx;
    logic [IW-1:0]       bs_idx;
    logic                match;
    logic                last_pos;
    logic                hold_done;
    logic [MAX_LEN-1:0]  len_mask;
    logic [MAX_LEN-1:0]  hit_now;

    // Address only moves in LOAD/CHECK/backspace, so it is settled a cycle before CHECK.
    assign cur_idx = counter[IW-1:0];
    assign bs_idx  = cur_idx - IW'(1);

    word_rom #(.LW(LW), .IW(IW)) u_rom (
        .clk  (clk),
        .addr ({level, cur_idx}),
        .data (rom_data)
    );

    assign key_up    = (bus.key_char >= LOWER_A && bus.key_char <= LOWER_Z)
                     ? bus.key_char - CASE_OFFSET : bus.key_char;
    assign key_print = (key_up >= ASCII_SPACE) && (key_up <= ASCII_DEL_MAX);
    assign key_bs    = (bus.key_char == ASCII_BS);

    assign match     = (rom_data == key_q);
    assign len_mask  = ~({MAX_LEN{1'b1}} << word_len);
    assign hit_now   = hit | ({{(MAX_LEN-1){1'b0}}, match} << cur_idx);
    assign last_pos  = (counter + 8'd1) == {4'd0, word_len};
    assign hold_done = bus.frame_tick && (32'(hold_cnt) + 1 == HOLD_FRAMES);

    // Game FSM with its counters and status record; start overrides everything
    // except in DONE, where it returns to IDLE.
    // NOTE: all state here uses non-blocking assignments under an async active-low
    // reset, so every register samples pre-edge values and reset needs no clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            level    <= '0;
            counter  <= '0;
            word_len <= '0;
            hit      <= '0;
            miss     <= '0;
            hold_cnt <= '0;
            key_q    <= '0;
        end else if (bus.start && state != DONE) begin
            level <= '0;
            state <= LOAD;
        end else begin
            case (state)
                IDLE: ;
                LOAD: begin
                    counter  <= '0;
                    hit      <= '0;
                    miss     <= '0;
                    word_len <= lvl_len(32'(level));
                    state    <= PLAY;
                end
                PLAY: begin
                    if (bus.key_valid) begin
                        if (key_print) begin
                            key_q <= key_up;
                            state <= CHECK;
                        end else if (key_bs && counter != 8'd0) begin
                            hit[bs_idx]  <= 1'b0;
                            miss[bs_idx] <= 1'b0;
                            counter      <= counter - 8'd1;
                        end
                    end
                end
                CHECK: begin
                    hit[cur_idx]  <= match;
                    miss[cur_idx] <= !match;
                    counter       <= counter + 8'd1;
                    hold_cnt      <= '0;
                    if (last_pos)
                        state <= ((hit_now & len_mask) == len_mask) ? WON : LOST;
                    else
                        state <= PLAY;
                end
                WON: begin
                    if (bus.frame_tick) begin
                        if (hold_done) begin
                            if (level == LW'(NUM_LEVELS - 1)) begin
                                state <= DONE;
                            end else begin
                                level <= level + 1'b1;
                                state <= LOAD;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                LOST: begin
                    if (bus.frame_tick) begin
                        if (hold_done) state <= LOAD;
                        else           hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        level <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.state    = state;
    assign bus.level    = level;
    assign bus.counter  = counter;
    assign bus.word_len = word_len;
    assign bus.hit      = hit;
    assign bus.miss     = miss;
    assign bus.lvl_won  = (state == WON);
    assign bus.game_won = (state == DONE);
endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer: reset, vector table, hand-written
// multi-cycle corners and a randomized run against a word-level game model.
module tb_level_sequencer;
    import level_pkg::*;

    localparam int HOLD = 120;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    level_sequencer_if bus ();

    level_sequencer #(.NUM_LEVELS(3), .MAX_LEN(8), .HOLD_FRAMES(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    string words [3] = '{"LOGIC", "FPGAVG", "FPGAVGA"};

    typedef struct {
        logic [7:0] key;
        int         cnt;
        int         hit;
        int         miss;
    } vec_t;
    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input int cnt, input int h, input int m, input state_t st);
        check({name, " counter"}, 32'(bus.counter), cnt);
        check({name, " hit"},     32'(bus.hit),     h);
        check({name, " miss"},    32'(bus.miss),    m);
        check({name, " state"},   32'(bus.state),   32'(st));
    endtask

    task automatic check_zero(input string name);
        check({name, " state"},    32'(bus.state),    32'(IDLE));
        check({name, " level"},    32'(bus.level),    0);
        check({name, " counter"},  32'(bus.counter),  0);
        check({name, " word_len"}, 32'(bus.word_len), 0);
        check({name, " hit"},      32'(bus.hit),      0);
        check({name, " miss"},     32'(bus.miss),     0);
        check({name, " lvl_won"},  32'(bus.lvl_won),  0);
        check({name, " game_won"}, 32'(bus.game_won), 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] c);
        bus.key_valid = 1'b1;
        bus.key_char  = c;
        step();
        bus.key_valid = 1'b0;
        step();
    endtask

    task automatic type_word(input string s);
        for (int i = 0; i < s.len(); i++) press(s[i]);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // n frame ticks with random idle gaps; optionally strobe a key with each tick
    task automatic ticks(input int n, input bit with_keys);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            if (with_keys) begin
                bus.key_valid = 1'b1;
                bus.key_char  = 8'h41;
            end
            step();
            bus.frame_tick = 1'b0;
            bus.key_valid  = 1'b0;
            if (i != n - 1 && $urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_level;
        bit res [$];
        int outcomes;

        tbl[0]  = '{8'h4C, 1, 'h01, 'h00};  // L
        tbl[1]  = '{8'h58, 2, 'h01, 'h02};  // X
        tbl[2]  = '{8'h08, 1, 'h01, 'h00};  // BS
        tbl[3]  = '{8'h4F, 2, 'h03, 'h00};  // O
        tbl[4]  = '{8'h08, 1, 'h01, 'h00};
        tbl[5]  = '{8'h08, 0, 'h00, 'h00};
        tbl[6]  = '{8'h08, 0, 'h00, 'h00};  // BS at 0 ignored
        tbl[7]  = '{8'h01, 0, 'h00, 'h00};  // control code ignored
        tbl[8]  = '{8'h6C, 1, 'h01, 'h00};  // l
        tbl[9]  = '{8'h6F, 2, 'h03, 'h00};  // o
        tbl[10] = '{8'h7E, 3, 'h03, 'h04};  // ~ printable, wrong
        tbl[11] = '{8'h7F, 3, 'h03, 'h04};  // DEL ignored
        tbl[12] = '{8'h0A, 3, 'h03, 'h04};  // LF ignored
        tbl[13] = '{8'h08, 2, 'h03, 'h00};
        tbl[14] = '{8'h67, 3, 'h07, 'h00};  // g
        tbl[15] = '{8'h69, 4, 'h0F, 'h00};  // i

        bus.start = 1'b0; bus.key_valid = 1'b0; bus.key_char = 8'h00; bus.frame_tick = 1'b0;
        reset = 1'b0;
        step(); step();
        check_zero("reset");
        reset = 1'b1;
        step();
        press(8'h4C);
        check_outs("idle key", 0, 0, 0, IDLE);

        pulse_start();
        check("start state", 32'(bus.state), 32'(LOAD));
        step();
        check("lvl0 word_len", 32'(bus.word_len), 5);
        check_outs("lvl0 entry", 0, 0, 0, PLAY);

        for (int i = 0; i < 16; i++) begin
            press(tbl[i].key);
            check_outs($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].hit, tbl[i].miss, PLAY);
        end

        // final letter: CHECK one cycle after the strobe, WON the cycle after
        bus.key_valid = 1'b1; bus.key_char = 8'h63;
        step();
        bus.key_valid = 1'b0;
        check("last key n+1 state", 32'(bus.state), 32'(CHECK));
        check("last key n+1 lvl_won", 32'(bus.lvl_won), 0);
        step();
        check("last key n+2 lvl_won", 32'(bus.lvl_won), 1);
        check_outs("win0", 5, 'h1F, 0, WON);

        ticks(HOLD - 1, 1'b1);
        check_outs("won hold", 5, 'h1F, 0, WON);
        ticks(1, 1'b0);
        check("won exit state", 32'(bus.state), 32'(LOAD));
        check("won exit level", 32'(bus.level), 1);
        step();
        check("lvl1 word_len", 32'(bus.word_len), 6);
        check_outs("lvl1 entry", 0, 0, 0, PLAY);

        // key held through CHECK is dropped
        bus.key_valid = 1'b1; bus.key_char = 8'h46;
        step();
        bus.key_char = 8'h5A;
        step();
        bus.key_valid = 1'b0;
        check_outs("key in check", 1, 'h01, 0, PLAY);
        type_word("PG");
        check_outs("lvl1 partial", 3, 'h07, 0, PLAY);

        // asynchronous reset mid-cycle
        #3 reset = 1'b0;
        #1 check_zero("mid reset");
        step();
        reset = 1'b1;
        step(); step();
        check("after reset state", 32'(bus.state), 32'(IDLE));
        check("after reset level", 32'(bus.level), 0);

        pulse_start();
        step();
        type_word("L");
        check_outs("pre restart", 1, 'h01, 0, PLAY);
        bus.start = 1'b1; bus.key_valid = 1'b1; bus.key_char = 8'h4F;
        step();
        bus.start = 1'b0; bus.key_valid = 1'b0;
        check("restart state", 32'(bus.state), 32'(LOAD));
        step();
        check_outs("restart", 0, 0, 0, PLAY);

        // losing attempt and retry
        type_word("LOXI");
        bus.key_valid = 1'b1; bus.key_char = 8'h43;
        step();
        bus.key_valid = 1'b0;
        check("lose n+1 state", 32'(bus.state), 32'(CHECK));
        step();
        check_outs("loxic", 5, 'h1B, 'h04, LOST);
        check("loxic lvl_won", 32'(bus.lvl_won), 0);
        ticks(HOLD - 1, 1'b1);
        check("lost hold state", 32'(bus.state), 32'(LOST));
        ticks(1, 1'b0);
        check("retry state", 32'(bus.state), 32'(LOAD));
        check("retry level", 32'(bus.level), 0);
        step();
        check_outs("retry entry", 0, 0, 0, PLAY);

        // full game
        for (int l = 0; l < 3; l++) begin
            type_word(words[l]);
            check_outs($sformatf("game lvl%0d", l), words[l].len(), (1 << words[l].len()) - 1, 0, WON);
            ticks(HOLD, 1'b0);
            if (l < 2) begin
                check($sformatf("game next lvl%0d", l), 32'(bus.level), l + 1);
                step();
                check($sformatf("game word_len%0d", l + 1), 32'(bus.word_len), words[l + 1].len());
            end
        end
        check("done state", 32'(bus.state), 32'(DONE));
        check("done game_won", 32'(bus.game_won), 1);
        check("done level", 32'(bus.level), 2);
        pulse_start();
        check("done->idle state", 32'(bus.state), 32'(IDLE));
        check("done->idle level", 32'(bus.level), 0);
        check("done->idle game_won", 32'(bus.game_won), 0);

        // randomized play against a word-level model
        pulse_start();
        step();
        m_level  = 0;
        outcomes = 0;
        res.delete();
        for (int it = 0; it < 400 && outcomes < 10; it++) begin
            int r;
            int hm;
            int mm;
            int wlen;
            logic [7:0] c;
            logic [7:0] up;
            logic [7:0] tgt;
            state_t exp_st;
            r    = $urandom_range(0, 99);
            wlen = words[m_level].len();
            if (r < 2) begin
                pulse_start();
                step();
                m_level = 0;
                res.delete();
                check("rnd restart level", 32'(bus.level), 0);
                check_outs("rnd restart", 0, 0, 0, PLAY);
                continue;
            end
            tgt = words[m_level][res.size()];
            if (r < 80)      c = ($urandom_range(0, 1) == 1) ? tgt + 8'h20 : tgt;
            else if (r < 88) c = 8'(8'h41 + $urandom_range(0, 25));
            else if (r < 94) c = ASCII_BS;
            else             c = 8'($urandom_range(0, 255));

            up = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
            exp_st = PLAY;
            if (up >= 8'h20 && up <= 8'h7E) begin
                res.push_back(up == tgt);
                if (res.size() == wlen) begin
                    exp_st = LOST;
                    if (!(0 inside {res})) exp_st = WON;
                end
            end else if (c == 8'h08 && res.size() > 0) begin
                void'(res.pop_back());
            end
            hm = 0;
            mm = 0;
            foreach (res[i]) begin
                if (res[i]) hm |= (1 << i);
                else        mm |= (1 << i);
            end

            press(c);
            check_outs($sformatf("rnd%0d", it), res.size(), hm, mm, exp_st);

            if (exp_st != PLAY) begin
                outcomes++;
                check("rnd lvl_won", 32'(bus.lvl_won), (exp_st == WON) ? 1 : 0);
                ticks(HOLD - 1, 1'b1);
                check("rnd hold state", 32'(bus.state), 32'(exp_st));
                ticks(1, 1'b0);
                if (exp_st == WON && m_level == 2) begin
                    check("rnd done", 32'(bus.game_won), 1);
                    pulse_start();
                    check("rnd idle", 32'(bus.state), 32'(IDLE));
                    pulse_start();
                    m_level = 0;
                end else begin
                    if (exp_st == WON) m_level++;
                    check("rnd load state", 32'(bus.state), 32'(LOAD));
                end
                check("rnd level", 32'(bus.level), m_level);
                step();
                check("rnd word_len", 32'(bus.word_len), words[m_level].len());
                res.delete();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/level_sequencer.md
# level_sequencer

Game controller for the typing-level display path. It owns the level index, the per-level letter counter and the per-position hit/miss record, and judges each keystroke against the target word read from a small word ROM. It decides level win, loss and retry, and whole-game completion. It sits between the keyboard decoder (ASCII strobe) and the level text renderers, which consume its registered status outputs every pixel.

## Interface
Parameters:
- NUM_LEVELS, 3, number of levels; level index width LW = $clog2(NUM_LEVELS).
- MAX_LEN, 8, maximum word length; sets status vector width and ROM index width.
- HOLD_FRAMES, 120, frame_tick pulses spent in WON/LOST before moving on.

Ports:
- clk  in  1  system clock (pixel-domain clock shared with renderers).
- reset  in  1  asynchronous, active-low reset.
- start  in  1  debounced one-cycle pulse; begins or restarts the game.
- key_valid  in  1  one-cycle strobe, key_char valid.
- key_char  in  8  ASCII code of the pressed key.
- frame_tick  in  1  one-cycle pulse per video frame.
- state  out  3  current FSM state encoding, used by the renderer to select a screen.
- level  out  LW  current level index.
- counter  out  8  letters accepted in the current attempt (0..word_len).
- word_len  out  4  length of the current target word.
- hit  out  MAX_LEN  bit i set when position i was typed correctly.
- miss  out  MAX_LEN  bit i set when position i was typed wrong.
- lvl_won  out  1  high while in WON.
- game_won  out  1  high while in DONE.

## Operation
- States: IDLE, LOAD, PLAY, CHECK, WON, LOST, DONE.
- IDLE:
  - level = 0.
  - start -> LOAD.
- LOAD (1 cycle):
  - counter <= 0; hit <= 0; miss <= 0.
  - word_len <= LVL_LEN[level].
  - Next state PLAY.
- PLAY:
  - key_valid with key_char 0x61..0x7A is uppercased (subtract 0x20).
  - Keys 0x20..0x7E are captured into key_q -> CHECK.
  - Backspace 0x08 with counter > 0 clears hit/miss[counter-1] and decrements counter; stay in PLAY.
  - Backspace with counter = 0 is ignored, as are all other codes.
- CHECK (1 cycle):
  - The ROM output is the target char at {level, counter}.
  - Equal to key_q: hit[counter] <= 1. Otherwise: miss[counter] <= 1.
  - counter <= counter + 1.
  - If counter + 1 == word_len: go to WON when (hit | this result) covers all word_len positions, else LOST.
  - Otherwise go to PLAY.
- WON:
  - Counts HOLD_FRAMES frame_ticks.
  - Then, if level == NUM_LEVELS-1 -> DONE; else level <= level + 1 -> LOAD.
- LOST: counts HOLD_FRAMES frame_ticks, then -> LOAD at the same level (retry).
- DONE: start -> IDLE.
- start in any state other than IDLE/DONE: level <= 0 -> LOAD (restart).
- hit and miss are never both set for one position. Bits at index >= word_len are always 0.

## Timing
- Reset values (async, reset = 0):
  - state = IDLE.
  - level, counter, word_len, hit, miss, hold counter, key_q all 0.
  - lvl_won = game_won = 0.
- All outputs are registered. lvl_won and game_won are decoded from the registered state, so they are glitch-free.
- Word ROM is synchronous with 1-cycle read latency. The address {level, counter} is stable for at least one cycle before CHECK, because counter changes only in LOAD/CHECK/backspace and PLAY always lasts at least 1 cycle.
- Key latency:
  - key_valid at cycle n (in PLAY).
  - hit/miss/counter updated at the edge ending cycle n+1.
  - Visible at cycle n+2.
- key_valid while in any state other than PLAY is dropped.
- Hold counter:
  - Cleared on entry to WON/LOST.
  - Increments only on frame_tick.
  - The exit transition is taken on the tick that makes the count equal HOLD_FRAMES.
- Simultaneous events:
  - start has priority over key_valid and frame_tick.
  - In PLAY, key_valid and start in the same cycle: the restart wins and the key is dropped.
- Reset mid-game: immediate return to IDLE, level 0, no partial state retained.

## Structure
- Package level_pkg:
  - State enum constants.
  - LVL_LEN[NUM_LEVELS] word lengths (5, 6, 7).
  - ASCII constants: ASCII_BS = 0x08, ASCII_SPACE = 0x20, ASCII_DEL_MAX = 0x7E, LOWER_A = 0x61, LOWER_Z = 0x7A.
- Sub-module word_rom:
  - Synchronous ROM, address {level, index}, 8-bit data.
  - Contents: level 0 "LOGIC", level 1 "FPGAVGA" truncated per LVL_LEN (defined in package).
  - Unused entries are 0x20.
- The FSM, counters and compare stay in level_sequencer.

## Test plan
- Reset low mid-PLAY at level 1 with counter 3 -> all outputs 0 and state IDLE within the same cycle; stay there after release until start.
- start, type "logic" (lowercase) at level 0 -> hit = 0x1F, miss = 0, counter = 5; lvl_won rises 2 cycles after the last strobe; after 120 frame_ticks, level = 1 and counter = 0.
- start, type "LOXIC" -> hit = 0x1B, miss = 0x04, state LOST; after 120 ticks LOAD at level 0 with hit = miss = 0.
- Type "LX", backspace, "O" -> counter = 2, hit = 0x03, miss = 0; backspace at counter 0 leaves all outputs unchanged.
- key_valid asserted during CHECK, WON and IDLE -> no change to counter, hit or miss; key_valid together with start in PLAY -> restart at level 0, key ignored.
- Win all three levels -> game_won = 1 in DONE; start -> IDLE, level 0.
